// File: rtl/twofish_pkg.sv
// Shared constants and FSM state encoding for the Twofish subkey sequencer.
package twofish_pkg;

    localparam int NUM_PAIRS   = 20;
    localparam int NUM_SUBKEYS = 2 * NUM_PAIRS;
    localparam int KEY_W       = 128;
    localparam int WORD_W      = 32;
    localparam int X_W         = 5;
    localparam int IDX_W       = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_FIN  = 2'd2
    } kg_state_t;

endpackage

// File: rtl/keygen.sv
// Combinational Twofish subkey pair generator for a 128-bit key.
// For pair index x it produces K[2x] on k0 and K[2x+1] on k1.
// keyM[127:120] is key byte m0; M0..M3 are little-endian words of m0..m15.
module keygen
    import twofish_pkg::*;
(
    input  logic [X_W-1:0]    x,
    input  logic [KEY_W-1:0]  keyM,
    output logic [WORD_W-1:0] k0,
    output logic [WORD_W-1:0] k1
);

    // Nibble tables t0..t3 of the q0 and q1 byte permutations.
    localparam logic [3:0] Q0_T [4][16] = '{
        '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2, 4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4},
        '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5, 4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD},
        '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0, 4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1},
        '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE, 4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA}
    };
    localparam logic [3:0] Q1_T [4][16] = '{
        '{4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE, 4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5},
        '{4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7, 4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8},
        '{4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA, 4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF},
        '{4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE, 4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA}
    };

    // q permutation: sel = 0 selects q0, sel = 1 selects q1.
    function automatic logic [7:0] q_perm(input logic sel, input logic [7:0] v);
        logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
        a0 = v[7:4];
        b0 = v[3:0];
        a1 = a0 ^ b0;
        b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
        a2 = sel ? Q1_T[0][a1] : Q0_T[0][a1];
        b2 = sel ? Q1_T[1][b1] : Q0_T[1][b1];
        a3 = a2 ^ b2;
        b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
        a4 = sel ? Q1_T[2][a3] : Q0_T[2][a3];
        b4 = sel ? Q1_T[3][b3] : Q0_T[3][b3];
        return {b4, a4};
    endfunction

    // GF(2^8) multiply, reduction polynomial x^8+x^6+x^5+x^3+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ sh;
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ 8'h69) : {sh[6:0], 1'b0};
        end
        return acc;
    endfunction

    // h function for a two-word key list (L0, L1) with all input bytes equal to y.
    function automatic logic [31:0] h_fn(input logic [7:0] y, input logic [31:0] l0,
                                         input logic [31:0] l1);
        logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
        y0 = q_perm(1'b1, q_perm(1'b0, q_perm(1'b0, y) ^ l1[7:0])   ^ l0[7:0]);
        y1 = q_perm(1'b0, q_perm(1'b0, q_perm(1'b1, y) ^ l1[15:8])  ^ l0[15:8]);
        y2 = q_perm(1'b1, q_perm(1'b1, q_perm(1'b0, y) ^ l1[23:16]) ^ l0[23:16]);
        y3 = q_perm(1'b0, q_perm(1'b1, q_perm(1'b1, y) ^ l1[31:24]) ^ l0[31:24]);
        z0 = y0 ^ gf_mul(y1, 8'hEF) ^ gf_mul(y2, 8'h5B) ^ gf_mul(y3, 8'h5B);
        z1 = gf_mul(y0, 8'h5B) ^ gf_mul(y1, 8'hEF) ^ gf_mul(y2, 8'hEF) ^ y3;
        z2 = gf_mul(y0, 8'hEF) ^ gf_mul(y1, 8'h5B) ^ y2 ^ gf_mul(y3, 8'hEF);
        z3 = gf_mul(y0, 8'hEF) ^ y1 ^ gf_mul(y2, 8'hEF) ^ gf_mul(y3, 8'h5B);
        return {z3, z2, z1, z0};
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [31:0] m0_w, m1_w, m2_w, m3_w;
    logic [31:0] a_w, b_raw, b_w, t_w;
    logic [7:0]  idx_even, idx_odd;

    assign m0_w     = bswap(keyM[127:96]);
    assign m1_w     = bswap(keyM[95:64]);
    assign m2_w     = bswap(keyM[63:32]);
    assign m3_w     = bswap(keyM[31:0]);
    assign idx_even = {2'b00, x, 1'b0};
    assign idx_odd  = {2'b00, x, 1'b1};

    // A uses the even key words, B the odd ones; B is rotated left by 8.
    assign a_w   = h_fn(idx_even, m0_w, m2_w);
    assign b_raw = h_fn(idx_odd, m1_w, m3_w);
    assign b_w   = {b_raw[23:0], b_raw[31:24]};
    assign t_w   = a_w + {b_w[30:0], 1'b0};

    assign k0 = a_w + b_w;
    assign k1 = {t_w[22:0], t_w[31:23]};

endmodule

// File: rtl/keygen_ctrl.sv
// Sequencer for keygen: latches a key, walks x = 0..19 one pair per clock,
// stores K0..K39 in a register file and serves them through a registered read port.
//
// Handshake: start is sampled only in IDLE; the accepting edge captures key_in
// and raises busy. busy stays high for exactly 20 cycles (one per x); the edge
// that writes x = 19 drops busy, raises key_valid and pulses done for one cycle.
// A FIN cycle follows in which start is ignored, so the earliest restart is two
// edges after the last write. key_valid falls on every accepting edge.
module keygen_ctrl
    import twofish_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  key_in,
    output logic              busy,
    output logic              done,
    output logic              key_valid,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_word,
    output logic [1:0]        state_dbg
);

    localparam logic [X_W-1:0] LAST_X = X_W'(NUM_PAIRS - 1);

    kg_state_t          state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic [WORD_W-1:0]  rd_word_q, rd_word_d;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx_even, wr_idx_odd;
    logic [WORD_W-1:0]  k0_w, k1_w;
    logic [WORD_W-1:0]  rf_q [NUM_SUBKEYS];

    keygen u_keygen (
        .x    (x_q),
        .keyM (key_q),
        .k0   (k0_w),
        .k1   (k1_w)
    );

    assign wr_idx_even = {x_q, 1'b0};
    assign wr_idx_odd  = {x_q, 1'b1};

    // Next-state and control: defaults hold everything, done is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        key_d   = key_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    x_d     = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                wr_en = 1'b1;
                if (x_q != LAST_X) begin
                    x_d = x_q + 5'd1;
                end else begin
                    x_d     = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Read mux: indices beyond the last subkey return zero.
    always_comb begin
        rd_word_d = '0;
        if (rd_idx < IDX_W'(NUM_SUBKEYS)) rd_word_d = rf_q[rd_idx];
    end

    // Control and read-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            key_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            rd_word_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            key_q     <= key_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            rd_word_q <= rd_word_d;
        end
    end

    // Subkey storage: two words per GEN edge, contents only meaningful with key_valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            rf_q[wr_idx_even] <= k0_w;
            rf_q[wr_idx_odd]  <= k1_w;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = valid_q;
    assign rd_word   = rd_word_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_keygen_ctrl.sv
// Self-checking bench for keygen_ctrl with a software Twofish key-schedule model.
module tb_keygen_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy, done, key_valid;
    logic [5:0]   rd_idx;
    logic [31:0]  rd_word;
    logic [1:0]   state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_k [40];
    logic [31:0] zero_k  [40];
    logic [31:0] nz_k    [40];

    localparam logic [127:0] NZ_KEY = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;

    keygen_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .rd_idx    (rd_idx),
        .rd_word   (rd_word),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    int qt [2][4][16] = '{
        '{'{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4},
          '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13},
          '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1},
          '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10}},
        '{'{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5},
          '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8},
          '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15},
          '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10}}};
    // which q (0/1) is applied at stage 0 (innermost), 1, 2 for each byte
    int qgrid [3][4] = '{'{0,1,0,1}, '{0,0,1,1}, '{1,0,1,0}};
    int mds   [4][4] = '{'{1,239,91,91}, '{91,239,239,1}, '{239,91,1,239}, '{239,1,239,91}};
    int q_tab [2][256];

    function automatic int ror4(int v);
        return ((v >> 1) | (v << 3)) & 15;
    endfunction

    function automatic int q_calc(int w, int v);
        int a0, b0, a1, b1, a2, b2, a3, b3;
        a0 = v / 16;  b0 = v % 16;
        a1 = a0 ^ b0; b1 = a0 ^ ror4(b0) ^ ((8 * a0) % 16);
        a2 = qt[w][0][a1]; b2 = qt[w][1][b1];
        a3 = a2 ^ b2; b3 = a2 ^ ror4(b2) ^ ((8 * a2) % 16);
        return 16 * qt[w][3][b3] + qt[w][2][a3];
    endfunction

    function automatic int gf_mul(int a, int b);
        int p = 0;
        for (int i = 0; i < 8; i++) if (((b >> i) & 1) == 1) p = p ^ (a << i);
        for (int bit_n = 14; bit_n >= 8; bit_n--)
            if (((p >> bit_n) & 1) == 1) p = p ^ ('h169 << (bit_n - 8));
        return p;
    endfunction

    function automatic logic [31:0] h_ref(int xb, logic [31:0] l0, logic [31:0] l1);
        int y [4];
        int v, zi;
        logic [31:0] z;
        for (int i = 0; i < 4; i++) begin
            v = xb;
            v = q_tab[qgrid[0][i]][v] ^ int'((l1 >> (8 * i)) & 32'hFF);
            v = q_tab[qgrid[1][i]][v] ^ int'((l0 >> (8 * i)) & 32'hFF);
            y[i] = q_tab[qgrid[2][i]][v];
        end
        z = '0;
        for (int i = 0; i < 4; i++) begin
            zi = 0;
            for (int j = 0; j < 4; j++) zi = zi ^ gf_mul(mds[i][j], y[j]);
            z = z | (32'(zi) << (8 * i));
        end
        return z;
    endfunction

    task automatic build_model(input logic [127:0] key);
        logic [31:0] mw [4];
        logic [31:0] a, b, t;
        for (int w = 0; w < 4; w++) begin
            mw[w] = '0;
            for (int bi = 0; bi < 4; bi++)
                mw[w] = mw[w] | (32'(key[127 - 8 * (4 * w + bi) -: 8]) << (8 * bi));
        end
        for (int i = 0; i < 20; i++) begin
            a = h_ref(2 * i, mw[0], mw[2]);
            b = h_ref(2 * i + 1, mw[1], mw[3]);
            b = (b << 8) | (b >> 24);
            t = a + 2 * b;
            model_k[2 * i]     = a + b;
            model_k[2 * i + 1] = (t << 9) | (t >> 23);
        end
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic accept(input logic [127:0] key, input bit hold);
        key_in = key;
        start  = 1'b1;
        tick();
        check("acc_busy", 32'(busy), 32'd1);
        check("acc_valid", 32'(key_valid), 32'd0);
        check("acc_state", 32'(state_dbg), 32'd1);
        if (!hold) start = 1'b0;
    endtask

    // Runs until busy falls; ends right after the edge that writes x = 19.
    task automatic finish_run(input int gen_done, input int change_at, input logic [127:0] alt,
                              input bit mon38, input logic [31:0] old38);
        int busy_cnt;
        int n;
        int guard;
        busy_cnt = 1 + gen_done;
        n = gen_done;
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            tick();
            n++;
            guard++;
            if (n == change_at) key_in = alt;
            if (busy === 1'b1) begin
                busy_cnt++;
                check("gen_done_low", 32'(done), 32'd0);
                check("gen_valid_low", 32'(key_valid), 32'd0);
            end
            if (mon38) check("gen_rd38_old", rd_word, old38);
        end
        check("busy_cycles", 32'(busy_cnt), 32'd20);
        check("done_pulse", 32'(done), 32'd1);
        check("valid_set", 32'(key_valid), 32'd1);
        check("fin_state", 32'(state_dbg), 32'd2);
    endtask

    task automatic post_run();
        tick();
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_valid", 32'(key_valid), 32'd1);
        check("post_state", 32'(state_dbg), 32'd0);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 40; i++) begin
            rd_idx = 6'(i);
            exp_q.push_back(model_k[i]);
            tick();
            check($sformatf("%s_k%0d", tag, i), rd_word, exp_q.pop_front());
        end
    endtask

    task automatic random_reads(input int count);
        int idx;
        for (int i = 0; i < count; i++) begin
            idx = $urandom_range(0, 63);
            rd_idx = 6'(idx);
            exp_q.push_back(idx < 40 ? model_k[idx] : 32'h0);
            tick();
            check($sformatf("rnd_rd%0d", idx), rd_word, exp_q.pop_front());
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] alt_key;
        logic [127:0] rkey;
        int done_seen;

        for (int w = 0; w < 2; w++)
            for (int v = 0; v < 256; v++) q_tab[w][v] = q_calc(w, v);
        build_model('0);
        zero_k = model_k;
        build_model(NZ_KEY);
        nz_k = model_k;

        // Reset
        rst = 1'b1; start = 1'b0; key_in = '0; rd_idx = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_rd_word", rd_word, 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // 1: zero key
        accept('0, 1'b0);
        finish_run(0, 0, '0, 1'b0, '0);
        post_run();
        rd_idx = 6'd0;
        tick();
        check("zero_k0_const", rd_word, 32'h52C54DDE);
        rd_idx = 6'd1;
        tick();
        check("zero_k1_const", rd_word, 32'h11F0626D);
        model_k = zero_k;
        sweep("zero");

        // 2: non-zero key, plus out-of-range reads
        accept(NZ_KEY, 1'b0);
        finish_run(0, 0, '0, 1'b0, '0);
        post_run();
        model_k = nz_k;
        sweep("nz");
        rd_idx = 6'd40;
        tick();
        check("rd_idx40", rd_word, 32'd0);
        rd_idx = 6'd63;
        tick();
        check("rd_idx63", rd_word, 32'd0);

        // 3: start held, key_in changed at GEN cycle 5
        alt_key = {$urandom(), $urandom(), $urandom(), $urandom()};
        rd_idx = 6'd2;
        accept('0, 1'b1);
        finish_run(0, 5, alt_key, 1'b0, '0);
        check("hold_rd_k2", rd_word, zero_k[2]);
        rd_idx = 6'd39;
        post_run();
        check("hold_rd_k39", rd_word, zero_k[39]);
        rd_idx = 6'd0;
        tick();
        check("e22_busy", 32'(busy), 32'd1);
        check("e22_valid", 32'(key_valid), 32'd0);
        check("e22_state", 32'(state_dbg), 32'd1);
        check("hold_rd_k0", rd_word, zero_k[0]);
        start = 1'b0;
        rd_idx = 6'd1;
        tick();
        check("hold_rd_k1", rd_word, zero_k[1]);
        finish_run(1, 0, '0, 1'b0, '0);
        post_run();
        build_model(alt_key);
        sweep("alt");

        // 4: reset in the middle of GEN
        accept('0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_valid", 32'(key_valid), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        check("mid_rst_rd", rd_word, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("mid_rst_quiet", 32'(done_seen), 32'd0);
        accept('0, 1'b0);
        finish_run(0, 0, '0, 1'b0, '0);
        post_run();
        model_k = zero_k;
        sweep("rerun");

        // 5/6: back-to-back keys, watching K38 during the second run
        rd_idx = 6'd38;
        accept(NZ_KEY, 1'b0);
        check("b2b_rd38_e0", rd_word, zero_k[38]);
        finish_run(0, 0, '0, 1'b1, zero_k[38]);
        post_run();
        check("b2b_rd38_new", rd_word, nz_k[38]);
        model_k = nz_k;
        sweep("b2b");

        // Random keys with random read indices
        for (int r = 0; r < 3; r++) begin
            rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
            accept(rkey, 1'b0);
            finish_run(0, 0, '0, 1'b0, '0);
            post_run();
            build_model(rkey);
            random_reads(20);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
